gray_decoder: RTL
=================

Name: gray_decoder

Overview:
Receive-side companion to the team's Gray-code counter. Samples a WIDTH-bit Gray code on each enabled clock, converts it to binary, and classifies the move from the previous code: hold, +1, −1, or illegal. Tracks wrap-arounds and raises sticky error and overflow flags. Sits between a Gray-coded position or pointer source and binary consumers.

Parameters:
WIDTH, 3, Gray/binary code width in bits (≥2).
WRAP_W, 4, WrapCount width in bits; counter wraps modulo 2^WRAP_W.

Ports:
Clk  input  1  clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-high reset.
En  input  1  sample strobe; GrayIn is accepted on a rising edge only while En=1.
GrayIn  input  WIDTH  Gray-coded input value.
Binary  output  WIDTH  registered binary decode of the last accepted sample.
Valid  output  1  one-cycle pulse, high in the cycle after each accepted sample.
Up  output  1  one-cycle pulse: last accepted move was a legal +1 step.
Down  output  1  one-cycle pulse: last accepted move was a legal −1 step (only with the feature macro).
WrapCount  output  WRAP_W  net wrap count: +1 on max→0, −1 on 0→max.
Overflow  output  1  sticky; set on the first forward wrap (max→0).
Error  output  1  sticky; set on the first illegal step.

Behaviour:
- Reset: Binary=0, Valid=0, Up=0, Down=0, WrapCount=0, Overflow=0, Error=0, state=IDLE. Reset takes priority over En in the same cycle.
- Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. Output is registered, so latency is 1 cycle from the accepting edge to Binary, Valid, Up and Down.
- En=0: nothing changes except Valid, Up and Down, which return to 0.
- delta = (b_new − Binary) mod 2^WIDTH, computed in WIDTH-bit wrap arithmetic.
- States:
  - IDLE: first accepted sample loads Binary and pulses Valid. No step check, no Up/Down. Go to TRACK.
  - TRACK, per accepted sample:
    - delta=0: hold; Valid only.
    - delta=1: pulse Up. If the previous Binary was all-ones, WrapCount+1 and Overflow←1.
    - delta=all-ones: legal only with the feature macro (see below); otherwise illegal.
    - any other delta: illegal. Error←1, no Up/Down, WrapCount unchanged, go to FAULT.
  - FAULT: each accepted sample still updates Binary and pulses Valid. No classification, Up/Down stay 0, WrapCount frozen. Leaves FAULT only on Reset.
- WrapCount wraps modulo 2^WRAP_W in both directions, with no saturation.
- Overflow and Error are never cleared except by Reset.
- Reset mid-operation (any state, any En) returns to IDLE. The next accepted sample is treated as the first.

Optional Feature:
GRAY_DOWN_ALLOW_EN
- Defined: delta=all-ones is a legal −1 step. Pulse Down. If the previous Binary was 0, WrapCount−1. Overflow is unaffected.
- Undefined: strict forward-only matching. delta=all-ones is illegal (Error, go to FAULT), and the Down port is tied to 0.

Test Plan:
1. WIDTH=3. Reset, then En=1 with GrayIn 000,001,011,010,110,111,101,100,000 on consecutive edges → Binary 0,1,2,3,4,5,6,7,0. Valid on all 9. Up on samples 2–9 (8 pulses). After the last sample: WrapCount=1, Overflow=1, Error=0.
2. Samples 011,011,011 → Binary=2 throughout, 3 Valid pulses, no Up, no Error.
3. Samples 001 then 010 (binary 1→3) → Error=1 one cycle after the second sample, no Up. Then 110 → Binary=4, Valid pulse, Up=0, WrapCount unchanged.
4. Samples 000 then 100 (0→7). With GRAY_DOWN_ALLOW_EN: Down pulse, WrapCount=15, Error=0. Without it: Error=1, Down=0.
5. After scenario 3, assert Reset with En=1 and GrayIn=111 → every output is 0 the next cycle. Then sample 111 → Binary=5, Valid, no Up, no Error (first sample after reset).
6. En=0 while GrayIn toggles randomly for 10 cycles → Binary, WrapCount and flags unchanged; Valid/Up/Down stay 0.

Source files
------------

// File: rtl/gray_decoder.sv
// gray_decoder: registered Gray-to-binary decode with step classification.
// Optional macro GRAY_DOWN_ALLOW_EN makes the -1 step legal and drives Down.
module gray_decoder #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [WIDTH-1:0]  GrayIn,
  output logic [WIDTH-1:0]  Binary,
  output logic              Valid,
  output logic              Up,
  output logic              Down,
  output logic [WRAP_W-1:0] WrapCount,
  output logic              Overflow,
  output logic              Error
);

  localparam logic [WIDTH-1:0] ALL1 = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic                valid_q, valid_d;
  logic                up_q, up_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic [WIDTH-1:0]    b_new;
  logic [WIDTH-1:0]    delta;
  logic                d_hold;
  logic                d_up;
  logic                prev_max;

`ifdef GRAY_DOWN_ALLOW_EN
  logic                down_q, down_d;
  logic                d_down;
  logic                prev_zero;
`endif

  // Gray-to-binary: each bit folds in all higher Gray bits
  always_comb begin
    b_new = GrayIn;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b_new[i] = b_new[i+1] ^ GrayIn[i];
    end
  end

  // Step size relative to the last accepted value, mod 2^WIDTH
  always_comb begin
    delta    = b_new - bin_q;
    d_hold   = (delta == ZERO);
    d_up     = (delta == ONE);
    prev_max = (bin_q == ALL1);
  end

`ifdef GRAY_DOWN_ALLOW_EN
  // Backward step detection
  always_comb begin
    d_down    = (delta == ALL1);
    prev_zero = (bin_q == ZERO);
  end
`endif

  // Next-state, classification and flag updates
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    up_d    = 1'b0;
    wrap_d  = wrap_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef GRAY_DOWN_ALLOW_EN
    down_d  = 1'b0;
`endif
    if (En) begin
      bin_d   = b_new;
      valid_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          state_d = TRACK;
        end
        TRACK: begin
          unique case (1'b1)
            d_hold: begin
            end
            d_up: begin
              up_d = 1'b1;
              if (prev_max) begin
                wrap_d = wrap_q + WRAP_W'(1);
                ovf_d  = 1'b1;
              end
            end
`ifdef GRAY_DOWN_ALLOW_EN
            d_down: begin
              down_d = 1'b1;
              if (prev_zero) begin
                wrap_d = wrap_q - WRAP_W'(1);
              end
            end
`endif
            default: begin
              err_d   = 1'b1;
              state_d = FAULT;
            end
          endcase
        end
        FAULT: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers, synchronous reset wins over En
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      wrap_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      up_q    <= up_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

`ifdef GRAY_DOWN_ALLOW_EN
  // Down pulse register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      down_q <= 1'b0;
    end else begin
      down_q <= down_d;
    end
  end

  assign Down = down_q;
`else
  assign Down = 1'b0;
`endif

  assign Binary    = bin_q;
  assign Valid     = valid_q;
  assign Up        = up_q;
  assign WrapCount = wrap_q;
  assign Overflow  = ovf_q;
  assign Error     = err_q;

endmodule
